// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register.
// Carries NCH GPR write channels and one HI/LO write channel. Each cycle it
// captures the MEM outputs, holds its contents for a WB stall, loads a NOP
// bubble for a MEM stall or a flush, and counts the real instructions that
// it accepts. Write enables are cleaned up before the register so the
// regfile never sees a write to r0, two writes to one register, or a write
// from an invalid slot.
module mem_wb_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NCH      = 2,
  parameter int CNT_W    = 32,
  parameter int ZERO_SUP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall_mem,
  input  logic                  stall_wb,
  input  logic                  mem_valid,
  input  logic [NCH*ADDR_W-1:0] mem_wd,
  input  logic [NCH-1:0]        mem_wreg,
  input  logic [NCH*DATA_W-1:0] mem_wdata,
  input  logic                  mem_whilo,
  input  logic [DATA_W-1:0]     mem_hi,
  input  logic [DATA_W-1:0]     mem_lo,
  output logic [NCH*ADDR_W-1:0] wb_wd,
  output logic [NCH-1:0]        wb_wreg,
  output logic [NCH*DATA_W-1:0] wb_wdata,
  output logic                  wb_whilo,
  output logic [DATA_W-1:0]     wb_hi,
  output logic [DATA_W-1:0]     wb_lo,
  output logic                  wb_valid,
  output logic [CNT_W-1:0]      retire_cnt
);

  logic [NCH*ADDR_W-1:0] wd_d,    wd_q;
  logic [NCH-1:0]        wreg_d,  wreg_q;
  logic [NCH*DATA_W-1:0] wdata_d, wdata_q;
  logic                  whilo_d, whilo_q;
  logic [DATA_W-1:0]     hi_d,    hi_q;
  logic [DATA_W-1:0]     lo_d,    lo_q;
  logic                  valid_d, valid_q;
  logic [CNT_W-1:0]      cnt_d,   cnt_q;

  logic [NCH-1:0]        wreg_san;
  logic                  load_nop;
  logic                  capture;

  // Sanitise the incoming GPR write enables: drop invalid slots, writes to
  // r0, and the lower-indexed twin of any duplicated destination.
  always_comb begin
    wreg_san = '0;
    for (int i = 0; i < NCH; i++) begin
      wreg_san[i] = mem_wreg[i] & mem_valid;
      if ((ZERO_SUP != 0) && (mem_wd[i*ADDR_W +: ADDR_W] == '0))
        wreg_san[i] = 1'b0;
      for (int j = i + 1; j < NCH; j++) begin
        if (mem_wreg[j] &&
            (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W]) &&
            (mem_wd[i*ADDR_W +: ADDR_W] != '0))
          wreg_san[i] = 1'b0;
      end
    end
  end

  // Choose between flush/bubble, hold and capture, and form the next state.
  // A bubble on a MEM stall keeps a stalled instruction from writing twice;
  // a WB stall outranks the bubble, and a flush outranks everything.
  always_comb begin
    load_nop = flush | (stall_mem & ~stall_wb);
    capture  = ~flush & ~stall_wb & ~stall_mem;

    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (load_nop) begin
      wd_d    = '0;
      wreg_d  = '0;
      wdata_d = '0;
      whilo_d = 1'b0;
      hi_d    = '0;
      lo_d    = '0;
      valid_d = 1'b0;
    end else if (capture) begin
      wd_d    = mem_wd;
      wreg_d  = wreg_san;
      wdata_d = mem_wdata;
      whilo_d = mem_whilo & mem_valid;
      hi_d    = mem_hi;
      lo_d    = mem_lo;
      valid_d = mem_valid;
      if (mem_valid)
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The WB register itself; reset returns every field to the NOP state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_wd      = wd_q;
  assign wb_wreg    = wreg_q;
  assign wb_wdata   = wdata_q;
  assign wb_whilo   = whilo_q;
  assign wb_hi      = hi_q;
  assign wb_lo      = lo_q;
  assign wb_valid   = valid_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a 2-channel instance with a 4-bit retire
// counter (so wrap is reachable) and a 3-channel instance for multi-channel
// sanitising.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 2-channel instance ----------------
  logic        rst, flush, stall_mem, stall_wb, mem_valid, mem_whilo;
  logic [9:0]  mem_wd;
  logic [1:0]  mem_wreg;
  logic [63:0] mem_wdata;
  logic [31:0] mem_hi, mem_lo;
  logic [9:0]  wb_wd;
  logic [1:0]  wb_wreg;
  logic [63:0] wb_wdata;
  logic        wb_whilo, wb_valid;
  logic [31:0] wb_hi, wb_lo;
  logic [3:0]  retire_cnt;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .NCH(2), .CNT_W(4), .ZERO_SUP(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_mem(stall_mem), .stall_wb(stall_wb),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_whilo(wb_whilo),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_valid(wb_valid), .retire_cnt(retire_cnt)
  );

  // ---------------- 3-channel instance ----------------
  logic        t_rst, t_flush, t_stall_mem, t_stall_wb, t_valid, t_whilo;
  logic [14:0] t_wd;
  logic [2:0]  t_wreg;
  logic [95:0] t_wdata;
  logic [31:0] t_hi, t_lo;
  logic [14:0] t_wb_wd;
  logic [2:0]  t_wb_wreg;
  logic [95:0] t_wb_wdata;
  logic        t_wb_whilo, t_wb_valid;
  logic [31:0] t_wb_hi, t_wb_lo;
  logic [7:0]  t_cnt;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5), .NCH(3), .CNT_W(8), .ZERO_SUP(1)) dut3 (
    .clk(clk), .rst(t_rst), .flush(t_flush), .stall_mem(t_stall_mem), .stall_wb(t_stall_wb),
    .mem_valid(t_valid), .mem_wd(t_wd), .mem_wreg(t_wreg), .mem_wdata(t_wdata),
    .mem_whilo(t_whilo), .mem_hi(t_hi), .mem_lo(t_lo),
    .wb_wd(t_wb_wd), .wb_wreg(t_wb_wreg), .wb_wdata(t_wb_wdata), .wb_whilo(t_wb_whilo),
    .wb_hi(t_wb_hi), .wb_lo(t_wb_lo), .wb_valid(t_wb_valid), .retire_cnt(t_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] wd, input logic [1:0] wr,
                       input logic [63:0] wdat, input logic hl,
                       input logic [31:0] hi, input logic [31:0] lo);
    mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
    mem_whilo = hl; mem_hi = hi; mem_lo = lo;
  endtask

  task automatic check_nop(input string tag);
    check({tag, "_wd"},    wb_wd,    '0);
    check({tag, "_wreg"},  wb_wreg,  '0);
    check({tag, "_wdata"}, wb_wdata, '0);
    check({tag, "_whilo"}, wb_whilo, '0);
    check({tag, "_hi"},    wb_hi,    '0);
    check({tag, "_lo"},    wb_lo,    '0);
    check({tag, "_valid"}, wb_valid, '0);
  endtask

  initial begin
    t_rst = 1'b1; t_flush = 1'b0; t_stall_mem = 1'b0; t_stall_wb = 1'b0;
    t_valid = 1'b0; t_whilo = 1'b0; t_wd = '0; t_wreg = '0; t_wdata = '0;
    t_hi = '0; t_lo = '0;

    // 1. reset with random inputs, two cycles
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      flush = 1'($urandom); stall_mem = 1'($urandom); stall_wb = 1'($urandom);
      drive(1'b1, 10'($urandom), 2'b11, {$urandom, $urandom}, 1'b1, $urandom, $urandom);
      step();
      check_nop("rst");
      check("rst_cnt", retire_cnt, 4'd0);
    end
    rst = 1'b0; flush = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
    drive(1'b1, {5'd3, 5'd8}, 2'b11, {32'hA, 32'hB}, 1'b1, 32'h1111, 32'h2222);
    #2;
    check("no_comb_path_valid", wb_valid, 1'b0);
    step();
    check("cap_wd",    wb_wd,    {5'd3, 5'd8});
    check("cap_wreg",  wb_wreg,  2'b11);
    check("cap_wdata", wb_wdata, {32'hA, 32'hB});
    check("cap_whilo", wb_whilo, 1'b1);
    check("cap_hi",    wb_hi,    32'h1111);
    check("cap_lo",    wb_lo,    32'h2222);
    check("cap_valid", wb_valid, 1'b1);
    check("cap_cnt",   retire_cnt, 4'd1);

    // 2. MEM stall inserts bubbles
    stall_mem = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_nop("bubble");
      check("bubble_cnt", retire_cnt, 4'd1);
    end
    stall_mem = 1'b0;

    // 3. WB stall holds; flush during stall wins
    drive(1'b1, {5'd4, 5'd9}, 2'b11, {32'hC, 32'hD}, 1'b0, 32'h3333, 32'h4444);
    step();
    check("cap2_wdata", wb_wdata, {32'hC, 32'hD});
    check("cap2_cnt",   retire_cnt, 4'd2);
    stall_wb = 1'b1;
    drive(1'b1, {5'd1, 5'd2}, 2'b01, {32'h5, 32'h6}, 1'b1, 32'h7, 32'h8);
    step();
    check("hold_wd",    wb_wd,    {5'd4, 5'd9});
    check("hold_wdata", wb_wdata, {32'hC, 32'hD});
    check("hold_wreg",  wb_wreg,  2'b11);
    stall_mem = 1'b1;
    drive(1'b1, {5'd6, 5'd6}, 2'b10, {32'h9, 32'h9}, 1'b1, 32'h9, 32'h9);
    step();
    check("hold2_wd",    wb_wd,    {5'd4, 5'd9});
    check("hold2_hi",    wb_hi,    32'h3333);
    check("hold2_valid", wb_valid, 1'b1);
    check("hold2_cnt",   retire_cnt, 4'd2);
    stall_mem = 1'b0;
    flush = 1'b1;
    step();
    check_nop("flush");
    check("flush_cnt", retire_cnt, 4'd2);
    flush = 1'b0; stall_wb = 1'b0;

    // 4. zero-register suppression and duplicate destinations
    drive(1'b1, {5'd5, 5'd0}, 2'b11, {32'h11, 32'h22}, 1'b0, 32'h0, 32'h0);
    step();
    check("zsup_wreg", wb_wreg, 2'b10);
    check("zsup_cnt",  retire_cnt, 4'd3);
    drive(1'b1, {5'd7, 5'd7}, 2'b11, {32'h33, 32'h44}, 1'b0, 32'h0, 32'h0);
    step();
    check("dup_wreg", wb_wreg, 2'b10);
    drive(1'b1, {5'd7, 5'd7}, 2'b01, {32'h33, 32'h44}, 1'b0, 32'h0, 32'h0);
    step();
    check("dup_off_wreg", wb_wreg, 2'b01);
    drive(1'b1, {5'd0, 5'd0}, 2'b11, {32'h55, 32'h66}, 1'b1, 32'h0, 32'h0);
    step();
    check("zz_wreg",  wb_wreg,  2'b00);
    check("zz_whilo", wb_whilo, 1'b1);
    check("zz_cnt",   retire_cnt, 4'd6);

    // 5. invalid slot: enables dropped, data still copied
    drive(1'b0, {5'd1, 5'd2}, 2'b11, {32'hE, 32'hF}, 1'b1, 32'hAB, 32'hCD);
    step();
    check("inv_wreg",  wb_wreg,  2'b00);
    check("inv_whilo", wb_whilo, 1'b0);
    check("inv_valid", wb_valid, 1'b0);
    check("inv_wdata", wb_wdata, {32'hE, 32'hF});
    check("inv_wd",    wb_wd,    {5'd1, 5'd2});
    check("inv_hi",    wb_hi,    32'hAB);
    check("inv_cnt",   retire_cnt, 4'd6);

    // 6. counter wrap after 17 valid captures
    rst = 1'b1;
    step();
    check("wrap_rst_cnt", retire_cnt, 4'd0);
    rst = 1'b0;
    drive(1'b1, {5'd3, 5'd8}, 2'b11, {32'h1, 32'h2}, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 17; k++) step();
    check("wrap_cnt", retire_cnt, 4'd1);

    // 3-channel instance
    t_rst = 1'b0;
    t_valid = 1'b1; t_wd = {5'd7, 5'd0, 5'd7}; t_wreg = 3'b111; t_wdata = {32'h3, 32'h2, 32'h1};
    step();
    check("n3_zero_dup_wreg", t_wb_wreg, 3'b100);
    check("n3_wdata", t_wb_wdata, {32'h3, 32'h2, 32'h1});
    check("n3_cnt1", t_cnt, 8'd1);
    t_wd = {5'd3, 5'd3, 5'd3};
    step();
    check("n3_triple_wreg", t_wb_wreg, 3'b100);
    t_wd = {5'd3, 5'd4, 5'd3}; t_wreg = 3'b011;
    step();
    check("n3_dup_off_wreg", t_wb_wreg, 3'b011);
    t_wd = {5'd9, 5'd3, 5'd3}; t_wreg = 3'b111;
    step();
    check("n3_low_pair_wreg", t_wb_wreg, 3'b110);
    t_valid = 1'b0; t_whilo = 1'b1;
    step();
    check("n3_inv_wreg",  t_wb_wreg,  3'b000);
    check("n3_inv_whilo", t_wb_whilo, 1'b0);
    check("n3_inv_cnt",   t_cnt, 8'd4);
    t_valid = 1'b1; t_stall_mem = 1'b1;
    step();
    check("n3_bubble_wreg",  t_wb_wreg,  3'b000);
    check("n3_bubble_valid", t_wb_valid, 1'b0);
    check("n3_bubble_cnt",   t_cnt, 8'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
